// File: rtl/data_sram_responder.sv
// Responder end of the SRAM-like data bus: a word RAM behind an in-order,
// fixed-latency response FIFO with a bounded number of outstanding requests.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        stall_i,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam int WORDS = 2 ** ADDR_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY);
  localparam logic [AGE_W-1:0] AGE_FIRE = AGE_W'(LATENCY - 1);

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    return (age == AGE_MAX) ? age : age + 1'b1;
  endfunction

  logic [31:0]       mem [WORDS];
  logic              fifo_rd   [DEPTH];
  logic [31:0]       fifo_data [DEPTH];
  logic [AGE_W-1:0]  fifo_age  [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       ram_word;
  logic [3:0]        be;
  logic [PTR_W-1:0]  nxt_head;
  logic              nxt_vld;
  logic              resp_fire;
  logic              unused_addr;

  assign data_addr_ok = !rst && !stall_i && (count < CNT_FULL);
  assign accept       = data_req && data_addr_ok;
  assign pop          = data_data_ok;
  assign word_idx     = data_addr[ADDR_W+1:2];
  assign ram_word     = mem[word_idx];
  assign be           = byte_en(data_size, data_addr[1:0]);
  assign unused_addr  = ^{data_addr[31:ADDR_W+2]};

  // Look past the entry being popped this edge so responses can issue back to back.
  assign nxt_head  = pop ? head + 1'b1 : head;
  assign nxt_vld   = pop ? (count > CNT_ONE) : (count != '0);
  assign resp_fire = nxt_vld && (fifo_age[nxt_head] == AGE_FIRE);

  // Accept edge: RAM update and read capture
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      mem[word_idx] <= merge_bytes(ram_word, data_wdata, be);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_age[i] <= age_inc(fifo_age[i]);
    end
    if (accept) begin
      fifo_rd[tail]   <= !data_wr;
      fifo_data[tail] <= ram_word;
      fifo_age[tail]  <= '0;
    end
  end

  // Response edge: FIFO pointers and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      count        <= count + CNT_W'(accept) - CNT_W'(pop);
      data_data_ok <= resp_fire;
      data_rdata   <= (resp_fire && fifo_rd[nxt_head]) ? fifo_data[nxt_head] : '0;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance at LATENCY=2/DEPTH=4
// and one at LATENCY=4/DEPTH=4, with per-instance accept/response logs.
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst;
  logic req_a, wr_a, stall_a, aok_a, dok_a;
  logic [1:0] size_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic req_b, wr_b, stall_b, aok_b, dok_b;
  logic [1:0] size_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int acc_a[$], re_a[$], acc_b[$], re_b[$];
  logic [31:0] rd_a[$], rd_b[$];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .data_req(req_a), .data_wr(wr_a), .data_size(size_a),
    .data_addr(addr_a), .data_wdata(wdata_a), .stall_i(stall_a),
    .data_addr_ok(aok_a), .data_data_ok(dok_a), .data_rdata(rdata_a));

  data_sram_responder #(.ADDR_W(10), .LATENCY(4), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .data_req(req_b), .data_wr(wr_b), .data_size(size_b),
    .data_addr(addr_b), .data_wdata(wdata_b), .stall_i(stall_b),
    .data_addr_ok(aok_b), .data_data_ok(dok_b), .data_rdata(rdata_b));

  always @(posedge clk) cyc <= cyc + 1;

  // Log accept edge numbers and response edge numbers / data.
  always @(negedge clk) begin
    if (req_a && aok_a) acc_a.push_back(cyc + 1);
    if (dok_a) begin re_a.push_back(cyc); rd_a.push_back(rdata_a); end
    if (req_b && aok_b) acc_b.push_back(cyc + 1);
    if (dok_b) begin re_b.push_back(cyc); rd_b.push_back(rdata_b); end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input bit b, input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    if (b) begin req_b = r; wr_b = w; size_b = s; addr_b = a; wdata_b = d; end
    else   begin req_a = r; wr_a = w; size_a = s; addr_a = a; wdata_a = d; end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; holds the request until it is accepted.
  task automatic issue(input bit b, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    drive(b, 1'b1, w, s, a, d);
    @(negedge clk);
    while (!(b ? aok_b : aok_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    drive(b, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic clear_logs();
    acc_a.delete(); re_a.delete(); rd_a.delete();
    acc_b.delete(); re_b.delete(); rd_b.delete();
  endtask

  task automatic chk_rsp(input bit b, input string tag, input int i, input int lat,
                         input logic [31:0] exp);
    int na, nr;
    na = b ? acc_b.size() : acc_a.size();
    nr = b ? re_b.size() : re_a.size();
    if (na > i && nr > i) begin
      check($sformatf("%s_lat%0d", tag, i),
            b ? (re_b[i] - acc_b[i]) : (re_a[i] - acc_a[i]), lat);
      check($sformatf("%s_data%0d", tag, i), b ? rd_b[i] : rd_a[i], exp);
    end else begin
      check($sformatf("%s_missing%0d", tag, i), 32'(nr), 32'(i + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_a = 1'b0;
    stall_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_aok_a", aok_a, 0);
    check("rst_dok_a", dok_a, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_aok_b", aok_b, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_aok_a", aok_a, 1);
    @(posedge clk);
    #1 clear_logs();

    // Word write then read-back
    issue(0, 1, 2'd2, 32'h100, 32'hDEADBEEF);
    issue(0, 0, 2'd2, 32'h100, 32'h0);
    wait_cyc(6);
    check("t1_nrsp", 32'(re_a.size()), 2);
    chk_rsp(0, "t1", 0, 2, 32'h0);
    chk_rsp(0, "t1", 1, 2, 32'hDEADBEEF);

    // Byte and half-word lane merges
    clear_logs();
    issue(0, 1, 2'd2, 32'h100, 32'h11223344);
    issue(0, 1, 2'd0, 32'h101, 32'h0000AA00);
    issue(0, 1, 2'd1, 32'h102, 32'h55660000);
    issue(0, 0, 2'd2, 32'h100, 32'h0);
    wait_cyc(6);
    check("t2_nrsp", 32'(re_a.size()), 4);
    chk_rsp(0, "t2", 3, 2, 32'h5566AA44);

    // Back-to-back: 8 writes then 8 reads with the request held high
    clear_logs();
    for (int i = 0; i < 8; i++) issue(0, 1, 2'd2, 32'h300 + 32'(4 * i), 32'hA5000000 + 32'(i));
    for (int i = 0; i < 8; i++) issue(0, 0, 2'd2, 32'h300 + 32'(4 * i), 32'h0);
    wait_cyc(6);
    check("t3_nrsp", 32'(re_a.size()), 16);
    if (acc_a.size() == 16 && re_a.size() == 16) begin
      check("t3_acc_span", 32'(acc_a[15] - acc_a[0]), 15);
      check("t3_rsp_span", 32'(re_a[15] - re_a[0]), 15);
    end
    for (int i = 0; i < 8; i++) chk_rsp(0, "t3w", i, 2, 32'h0);
    for (int i = 0; i < 8; i++) chk_rsp(0, "t3r", 8 + i, 2, 32'hA5000000 + 32'(i));

    // Read-after-write to the same word on consecutive cycles
    clear_logs();
    issue(0, 1, 2'd2, 32'h200, 32'h12345678);
    issue(0, 1, 2'd2, 32'h200, 32'h0);
    issue(0, 0, 2'd2, 32'h200, 32'h0);
    wait_cyc(6);
    check("t6_nrsp", 32'(re_a.size()), 3);
    chk_rsp(0, "t6", 2, 2, 32'h0);

    // Strict full at LATENCY=4 with stall toggling
    clear_logs();
    issue(1, 1, 2'd2, 32'h500, 32'hCAFE0001);
    stall_b = 1'b1;
    drive(1, 1'b1, 1'b1, 2'd2, 32'h504, 32'hCAFE0002);
    @(negedge clk);
    check("t4_stall_aok", aok_b, 0);
    @(posedge clk);
    #1 stall_b = 1'b0;
    issue(1, 1, 2'd2, 32'h504, 32'hCAFE0002);
    issue(1, 1, 2'd2, 32'h508, 32'hCAFE0003);
    issue(1, 1, 2'd2, 32'h50C, 32'hCAFE0004);
    drive(1, 1'b1, 1'b0, 2'd2, 32'h500, 32'h0);
    @(negedge clk);
    check("t4_full_aok", aok_b, 0);
    check("t4_full_pop", dok_b, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_after_pop_aok", aok_b, 1);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    wait_cyc(10);
    check("t4_nrsp", 32'(re_b.size()), 5);
    if (acc_b.size() == 5) check("t4_acc_gap", 32'(acc_b[4] - acc_b[3]), 2);
    for (int i = 0; i < 4; i++) chk_rsp(1, "t4w", i, 4, 32'h0);
    chk_rsp(1, "t4r", 4, 4, 32'hCAFE0001);

    // Reset with three requests in flight
    clear_logs();
    issue(1, 1, 2'd2, 32'h400, 32'h0BAD0000);
    issue(1, 1, 2'd2, 32'h404, 32'h0BAD0001);
    issue(1, 1, 2'd2, 32'h408, 32'h0BAD0002);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_aok", aok_b, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_dok", dok_b, 0);
    check("t5_rst_rdata", rdata_b, 0);
    check("t5_aok_back", aok_b, 1);
    @(posedge clk);
    #1;
    wait_cyc(8);
    check("t5_no_rsp", 32'(re_b.size()), 0);
    clear_logs();
    issue(1, 0, 2'd2, 32'h400, 32'h0);
    issue(1, 0, 2'd2, 32'h404, 32'h0);
    issue(1, 0, 2'd2, 32'h408, 32'h0);
    wait_cyc(8);
    check("t5_nrsp", 32'(re_b.size()), 3);
    for (int i = 0; i < 3; i++) chk_rsp(1, "t5r", i, 4, 32'h0BAD0000 + 32'(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
